// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - lane runner play/pause/countdown/invulnerability sequencer
module game_state_controller #(
  parameter int CNT_W            = 8,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int INVULN_FRAMES    = 90,
  parameter int BLINK_FRAMES     = 8
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       frame_tick,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       collision_raw,
  input  logic       game_over,
  output logic       collision_pulse,
  output logic       restart_pulse,
  output logic       run_enable,
  output logic       player_visible,
  output logic       invuln_active,
  output logic [2:0] state_code
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAYING   = 3'd2,
    INVULN    = 3'd3,
    PAUSED    = 3'd4,
    OVER      = 3'd5
  } state_e;

  localparam int BLK_W = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_COUNTDOWN = CNT_W'(COUNTDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_INVULN    = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [BLK_W-1:0] BLK_RELOAD    = BLK_W'(BLINK_FRAMES);
  localparam logic [BLK_W-1:0] BLK_ONE       = BLK_W'(1);

  // Kept as a raw 3-bit register so the unused codes 6-7 are representable and can be recovered
  logic [2:0]       state_q;
  state_e           state_d;
  state_e           ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blink_q, blink_d;
  logic             start_prev_q, pause_prev_q, coll_prev_q;
  logic             cpulse_q, cpulse_d;
  logic             rpulse_q, rpulse_d;
  logic             run_q, run_d;
  logic             vis_q, vis_d;
  logic             inv_q, inv_d;

  logic start_rise, pause_rise, coll_rise;

  assign start_rise = start_key     & ~start_prev_q;
  assign pause_rise = pause_key     & ~pause_prev_q;
  assign coll_rise  = collision_raw & ~coll_prev_q;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d  = state_e'(state_q);
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    vis_d    = vis_q;
    cpulse_d = 1'b0;
    rpulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        vis_d = 1'b1;
        if (start_rise) begin
          cnt_d   = CNT_COUNTDOWN;
          state_d = COUNTDOWN;
        end
      end

      COUNTDOWN: begin
        vis_d = 1'b1;
        if (frame_tick) begin
          // Treat 0 like 1 so a bad load can never stall the countdown
          if (cnt_q <= CNT_ONE) begin
            state_d = PLAYING;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      PLAYING: begin
        vis_d = 1'b1;
        if (game_over) begin
          state_d = OVER;
        end else if (pause_rise) begin
          ret_d   = PLAYING;
          state_d = PAUSED;
        end else if (coll_rise) begin
          cpulse_d = 1'b1;
          cnt_d    = CNT_INVULN;
          blink_d  = BLK_RELOAD;
          vis_d    = 1'b0;
          state_d  = INVULN;
        end
      end

      INVULN: begin
        if (game_over) begin
          vis_d   = 1'b1;
          state_d = OVER;
        end else if (pause_rise) begin
          ret_d   = INVULN;
          state_d = PAUSED;
        end else if (frame_tick) begin
          if (cnt_q <= CNT_ONE) begin
            vis_d   = 1'b1;
            state_d = PLAYING;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (blink_q <= BLK_ONE) begin
              blink_d = BLK_RELOAD;
              vis_d   = ~vis_q;
            end else begin
              blink_d = blink_q - BLK_ONE;
            end
          end
        end
      end

      PAUSED: begin
        // Game over is terminal, so it outranks an unpause on the same edge
        if (game_over) begin
          vis_d   = 1'b1;
          state_d = OVER;
        end else if (pause_rise) begin
          state_d = ret_q;
        end
      end

      OVER: begin
        vis_d = 1'b1;
        if (start_rise) begin
          rpulse_d = 1'b1;
          cnt_d    = CNT_COUNTDOWN;
          state_d  = COUNTDOWN;
        end
      end

      default: begin
        vis_d   = 1'b1;
        state_d = IDLE;
      end
    endcase

    run_d = (state_d == PLAYING) || (state_d == INVULN);
    inv_d = (state_d == INVULN) || ((state_d == PAUSED) && (ret_d == INVULN));
  end

  // State, counters, edge-detect history and registered outputs
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      ret_q        <= PLAYING;
      cnt_q        <= '0;
      blink_q      <= '0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      coll_prev_q  <= 1'b0;
      cpulse_q     <= 1'b0;
      rpulse_q     <= 1'b0;
      run_q        <= 1'b0;
      vis_q        <= 1'b1;
      inv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      cnt_q        <= cnt_d;
      blink_q      <= blink_d;
      start_prev_q <= start_key;
      pause_prev_q <= pause_key;
      coll_prev_q  <= collision_raw;
      cpulse_q     <= cpulse_d;
      rpulse_q     <= rpulse_d;
      run_q        <= run_d;
      vis_q        <= vis_d;
      inv_q        <= inv_d;
    end
  end

  assign collision_pulse = cpulse_q;
  assign restart_pulse   = rpulse_q;
  assign run_enable      = run_q;
  assign player_visible  = vis_q;
  assign invuln_active   = inv_q;
  assign state_code      = state_q;

endmodule

// File: tb/tb_game_state_controller.sv
// tb/tb_game_state_controller.sv - table-driven bench for game_state_controller
module tb_game_state_controller;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       frame_tick;
  logic       start_key;
  logic       pause_key;
  logic       collision_raw;
  logic       game_over;
  logic       collision_pulse;
  logic       restart_pulse;
  logic       run_enable;
  logic       player_visible;
  logic       invuln_active;
  logic [2:0] state_code;

  logic go_man;
  logic hnd_arm;
  logic hnd_go;

  int errors = 0;
  int checks = 0;
  int viol   = 0;
  bit prev_pulse = 1'b0;

  game_state_controller dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .frame_tick      (frame_tick),
    .start_key       (start_key),
    .pause_key       (pause_key),
    .collision_raw   (collision_raw),
    .game_over       (game_over),
    .collision_pulse (collision_pulse),
    .restart_pulse   (restart_pulse),
    .run_enable      (run_enable),
    .player_visible  (player_visible),
    .invuln_active   (invuln_active),
    .state_code      (state_code)
  );

  always #5 Clock = ~Clock;

  // Lives-handler stand-in: last life, game over one edge after it samples a collision strobe
  always @(posedge Clock) begin
    if (!Resetn || restart_pulse) hnd_go <= 1'b0;
    else if (collision_pulse && hnd_arm) hnd_go <= 1'b1;
  end

  assign game_over = hnd_go | go_man;

  // Strobes must never overlap nor appear on consecutive cycles
  always @(negedge Clock) begin
    if (collision_pulse && restart_pulse) viol++;
    if (prev_pulse && (collision_pulse || restart_pulse)) viol++;
    prev_pulse = collision_pulse || restart_pulse;
  end

  typedef struct {
    int         n;
    bit         rst, start, pause, coll, go, tick, arm;
    logic [2:0] st;
    bit         run, vis, inv;
    int         cpn, rpn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int n, input bit rst, input bit start, input bit pause,
                              input bit coll, input bit go, input bit tick, input bit arm,
                              input int st, input bit run, input bit vis, input bit inv,
                              input int cpn, input int rpn);
    vec_t t;
    t.n = n; t.rst = rst; t.start = start; t.pause = pause; t.coll = coll;
    t.go = go; t.tick = tick; t.arm = arm; t.st = 3'(st); t.run = run;
    t.vis = vis; t.inv = inv; t.cpn = cpn; t.rpn = rpn;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int cpn = 0;
    int rpn = 0;
    Resetn        = ~t.rst;
    start_key     = t.start;
    pause_key     = t.pause;
    collision_raw = t.coll;
    go_man        = t.go;
    frame_tick    = t.tick;
    hnd_arm       = t.arm;
    repeat (t.n) begin
      @(posedge Clock);
      @(negedge Clock);
      cpn += int'(collision_pulse);
      rpn += int'(restart_pulse);
    end
    check($sformatf("vec%0d {st,run,vis,inv,cpn,rpn}", idx),
          {13'd0, state_code, run_enable, player_visible, invuln_active, 8'(cpn), 8'(rpn)},
          {13'd0, t.st, t.run, t.vis, t.inv, 8'(t.cpn), 8'(t.rpn)});
  endtask

  initial begin
    //            n  rs st pa co go tk ar  st rn vs iv cp rp
    vecs.push_back(mk(  1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0)); // start -> countdown
    vecs.push_back(mk(179, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0)); // one tick short
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 0, 0, 0)); // tick 180 -> playing
    vecs.push_back(mk(  1, 0, 0, 0, 1, 0, 0, 0,  3, 1, 0, 1, 1, 0)); // hit
    vecs.push_back(mk( 19, 0, 0, 0, 1, 0, 0, 0,  3, 1, 0, 1, 0, 0)); // held collision, no pulse
    vecs.push_back(mk(  7, 0, 0, 0, 0, 0, 1, 0,  3, 1, 0, 1, 0, 0)); // blink not yet
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 1, 0,  3, 1, 1, 1, 0, 0)); // tick 8 toggles
    vecs.push_back(mk(  8, 0, 0, 0, 0, 0, 1, 0,  3, 1, 0, 1, 0, 0)); // tick 16 toggles
    vecs.push_back(mk( 24, 0, 0, 0, 0, 0, 1, 0,  3, 1, 1, 1, 0, 0)); // 40 ticks
    vecs.push_back(mk(  1, 0, 0, 1, 0, 0, 0, 0,  4, 0, 1, 1, 0, 0)); // pause in invuln
    vecs.push_back(mk(100, 0, 0, 0, 0, 0, 1, 0,  4, 0, 1, 1, 0, 0)); // ticks while paused
    vecs.push_back(mk(  1, 0, 0, 1, 0, 0, 0, 0,  3, 1, 1, 1, 0, 0)); // resume invuln
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 0, 0,  3, 1, 1, 1, 0, 0));
    vecs.push_back(mk( 49, 0, 0, 0, 0, 0, 1, 0,  3, 1, 1, 1, 0, 0)); // 89 effective ticks
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 0, 0, 0)); // tick 90 -> playing
    vecs.push_back(mk(  1, 0, 0, 1, 1, 0, 0, 0,  4, 0, 1, 0, 0, 0)); // pause+collision
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 0, 0,  4, 0, 1, 0, 0, 0));
    vecs.push_back(mk(  1, 0, 0, 1, 0, 0, 0, 0,  2, 1, 1, 0, 0, 0)); // resume playing
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 0, 0,  2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(  1, 0, 0, 1, 0, 1, 0, 0,  5, 0, 1, 0, 0, 0)); // game_over beats pause
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 0, 0,  5, 0, 1, 0, 0, 0));
    vecs.push_back(mk(  1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1)); // restart
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(180, 0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(  1, 0, 0, 0, 1, 0, 0, 1,  3, 1, 0, 1, 1, 0)); // last-life hit
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 0, 1,  3, 1, 0, 1, 0, 0)); // handler latency
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 0, 0,  5, 0, 1, 0, 0, 0)); // over
    vecs.push_back(mk(  1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(180, 0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(  1, 0, 0, 0, 1, 0, 0, 0,  3, 1, 0, 1, 1, 0));
    vecs.push_back(mk(  1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0)); // reset mid-invuln
    vecs.push_back(mk(  1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0)); // no restart pulse from idle
    vecs.push_back(mk(180, 0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(  1, 0, 0, 1, 0, 0, 0, 0,  4, 0, 1, 0, 0, 0));
    vecs.push_back(mk(  1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0)); // reset mid-paused
    vecs.push_back(mk(  1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(180, 0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(  1, 0, 0, 0, 1, 0, 0, 0,  3, 1, 0, 1, 1, 0));
    vecs.push_back(mk( 90, 0, 0, 0, 1, 0, 1, 0,  2, 1, 1, 0, 0, 0)); // held across expiry
    vecs.push_back(mk(  3, 0, 0, 0, 1, 0, 0, 0,  2, 1, 1, 0, 0, 0)); // still no pulse
    vecs.push_back(mk(  1, 0, 0, 0, 0, 0, 0, 0,  2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(  1, 0, 0, 0, 1, 0, 0, 0,  3, 1, 0, 1, 1, 0)); // fresh rise hits
    vecs.push_back(mk(  1, 0, 0, 0, 0, 1, 0, 0,  5, 0, 1, 0, 0, 0)); // over from invuln

    Resetn = 1'b0; start_key = 1'b0; pause_key = 1'b0; collision_raw = 1'b0;
    go_man = 1'b0; frame_tick = 1'b0; hnd_arm = 1'b0;
    repeat (2) @(negedge Clock);
    check("reset {st,run,vis,inv,cp,rp}",
          {26'd0, state_code, run_enable, player_visible, invuln_active, collision_pulse, restart_pulse},
          {26'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Illegal state code recovers to IDLE on the next edge
    Resetn = 1'b1; start_key = 1'b0; pause_key = 1'b0; collision_raw = 1'b0;
    go_man = 1'b0; frame_tick = 1'b0; hnd_arm = 1'b0;
    @(negedge Clock);
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    @(posedge Clock);
    @(negedge Clock);
    check("illegal->idle {st,run,vis}",
          {27'd0, state_code, run_enable, player_visible},
          {27'd0, 3'd0, 1'b0, 1'b1});

    // Game over while paused goes straight to OVER
    start_key = 1'b1;
    @(posedge Clock); @(negedge Clock);
    start_key = 1'b0; frame_tick = 1'b1;
    repeat (180) begin @(posedge Clock); @(negedge Clock); end
    frame_tick = 1'b0; pause_key = 1'b1;
    @(posedge Clock); @(negedge Clock);
    check("paused {st}", {29'd0, state_code}, {29'd0, 3'd4});
    pause_key = 1'b0; go_man = 1'b1;
    @(posedge Clock); @(negedge Clock);
    go_man = 1'b0;
    check("paused+go {st,run,vis}",
          {27'd0, state_code, run_enable, player_visible},
          {27'd0, 3'd5, 1'b0, 1'b1});

    check("pulse overlap/back-to-back count", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
